// File: rtl/ysyx22041405_pkg.sv
// Shared definitions for the ysyx22041405 core: inter-stage bundle widths, load masks,
// load/store funct3 codes, LSU state encodings and small lane helpers.
package ysyx22041405_pkg;

    localparam int IF_ID_WIDTH       = 64;
    localparam int EX_BASE_MES_WIDTH = 141;
    localparam int LS_DATA_WIDTH     = 133;
    localparam int LS_CTRL_WIDTH     = 11;
    localparam int LS_WB_WIDTH       = LS_DATA_WIDTH + LS_CTRL_WIDTH;

    localparam logic [7:0] MASK_BYTE = 8'h01;
    localparam logic [7:0] MASK_HALF = 8'h03;
    localparam logic [7:0] MASK_WORD = 8'h0F;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LS_IDLE = 2'b00,
        LS_REQ  = 2'b01,
        LS_WAIT = 2'b10
    } ls_state_e;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b01:   return addr[0];
            2'b10:   return addr != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic store_illegal(input logic [2:0] funct3);
        return funct3[2] || (funct3[1:0] == 2'b11);
    endfunction

    function automatic logic [7:0] load_rmask(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   return MASK_BYTE;
            2'b01:   return MASK_HALF;
            2'b10:   return MASK_WORD;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3[1:0])
            2'b00:   return 4'b0001 << addr;
            2'b01:   return 4'b0011 << addr;
            default: return 4'b1111;
        endcase
    endfunction

    // Narrow stores replicate across lanes so the strobe alone selects the bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0] funct3, input logic [31:0] data);
        case (funct3[1:0])
            2'b00:   return {4{data[7:0]}};
            2'b01:   return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/ysyx22041405_load_ext.sv
// Load data aligner: shifts the bus word down to the addressed byte lane and
// sign/zero-extends it according to funct3; flags funct3 codes that are not loads.
module ysyx22041405_load_ext
    import ysyx22041405_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rdata,
    input  logic [1:0]       addr,
    input  logic [2:0]       funct3,
    output logic [WIDTH-1:0] ext_data,
    output logic             illegal
);

    logic [WIDTH-1:0]   shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    assign shifted = rdata >> {addr, 3'b000};
    assign byte_s  = shifted[7:0];
    assign half_s  = shifted[15:0];

    always_comb begin
        ext_data = '0;
        illegal  = 1'b0;
        case (funct3)
            F3_LB:   ext_data = WIDTH'(byte_s);
            F3_LBU:  ext_data = WIDTH'(shifted[7:0]);
            F3_LH:   ext_data = WIDTH'(half_s);
            F3_LHU:  ext_data = WIDTH'(shifted[15:0]);
            F3_LW:   ext_data = shifted;
            default: illegal  = 1'b1;
        endcase
    end

endmodule

// File: rtl/ysyx22041405_lsu.sv
// Load/store stage: single-outstanding data-memory transactions with a registered
// LS->WB bundle that is all-zero (a bubble) in every cycle nothing retires.
module ysyx22041405_lsu
    import ysyx22041405_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [31:0]            ex_pc,
    input  logic [31:0]            ex_inst,
    input  logic [WIDTH-1:0]       ex_alu_result,
    input  logic [WIDTH-1:0]       ex_store_data,
    input  logic [4:0]             ex_rf_waddr,
    input  logic                   ex_rf_we,
    input  logic                   ex_mem_re,
    input  logic                   ex_mem_we,
    input  logic [2:0]             ex_funct3,
    input  logic                   ex_ebreak,
    input  logic                   ex_inst_valid,
    output logic                   dm_req,
    output logic                   dm_we,
    output logic [WIDTH-1:0]       dm_addr,
    output logic [WIDTH-1:0]       dm_wdata,
    output logic [3:0]             dm_wstrb,
    input  logic                   dm_gnt,
    input  logic                   dm_rvalid,
    input  logic [WIDTH-1:0]       dm_rdata,
    output logic [LS_WB_WIDTH-1:0] LS_WB_message,
    output logic                   ls_busy
);

    ls_state_e              state;
    logic [31:0]            hold_pc_p1;
    logic [31:0]            hold_inst_p1;
    logic [WIDTH-1:0]       hold_addr_p1;
    logic [WIDTH-1:0]       hold_sdata_p1;
    logic [4:0]             hold_waddr_p1;
    logic                   hold_rf_we_p1;
    logic                   hold_we_p1;
    logic [2:0]             hold_funct3_p1;
    logic                   hold_ebreak_p1;
    logic                   hold_inst_valid_p1;
    logic [LS_WB_WIDTH-1:0] ls_wb_p2;

    logic             accept;
    logic             is_mem;
    logic             access_bad;
    logic [1:0]       ext_addr;
    logic [2:0]       ext_funct3;
    logic [WIDTH-1:0] ext_data;
    logic             ext_illegal;

    assign ex_ready      = (state == LS_IDLE);
    assign ls_busy       = (state != LS_IDLE);
    assign accept        = ex_valid && ex_ready;
    assign is_mem        = ex_mem_re || ex_mem_we;
    assign dm_req        = (state == LS_REQ);
    assign dm_we         = hold_we_p1;
    assign dm_addr       = hold_addr_p1;
    assign dm_wdata      = store_wdata(hold_funct3_p1, hold_sdata_p1);
    assign dm_wstrb      = store_strb(hold_funct3_p1, hold_addr_p1[1:0]);
    assign LS_WB_message = ls_wb_p2;

    // The extender legality-checks the incoming load in IDLE and aligns returning data later.
    assign ext_addr   = (state == LS_IDLE) ? ex_alu_result[1:0] : hold_addr_p1[1:0];
    assign ext_funct3 = (state == LS_IDLE) ? ex_funct3 : hold_funct3_p1;

    assign access_bad = is_misaligned(ex_funct3, ex_alu_result[1:0]) ||
                        (ex_mem_re ? ext_illegal : store_illegal(ex_funct3));

    ysyx22041405_load_ext #(.WIDTH(WIDTH)) u_load_ext (
        .rdata    (dm_rdata),
        .addr     (ext_addr),
        .funct3   (ext_funct3),
        .ext_data (ext_data),
        .illegal  (ext_illegal)
    );

    // p1: holding register / FSM, p2: LS->WB output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= LS_IDLE;
            hold_pc_p1         <= '0;
            hold_inst_p1       <= '0;
            hold_addr_p1       <= '0;
            hold_sdata_p1      <= '0;
            hold_waddr_p1      <= '0;
            hold_rf_we_p1      <= 1'b0;
            hold_we_p1         <= 1'b0;
            hold_funct3_p1     <= '0;
            hold_ebreak_p1     <= 1'b0;
            hold_inst_valid_p1 <= 1'b0;
            ls_wb_p2           <= '0;
        end else begin
            ls_wb_p2 <= '0;
            case (state)
                LS_IDLE: begin
                    if (accept) begin
                        if (!is_mem) begin
                            ls_wb_p2 <= {ex_rf_waddr, ex_alu_result, 32'h0, ex_pc, ex_inst,
                                         ex_ebreak, ex_inst_valid, ex_rf_we, 8'h00};
                        end else if (access_bad) begin
                            ls_wb_p2 <= {ex_rf_waddr, 32'h0, 32'h0, ex_pc, ex_inst,
                                         ex_ebreak, 1'b0, 1'b0, 8'h00};
                        end else begin
                            hold_pc_p1         <= ex_pc;
                            hold_inst_p1       <= ex_inst;
                            hold_addr_p1       <= ex_alu_result;
                            hold_sdata_p1      <= ex_store_data;
                            hold_waddr_p1      <= ex_rf_waddr;
                            hold_rf_we_p1      <= ex_rf_we;
                            hold_we_p1         <= ex_mem_we;
                            hold_funct3_p1     <= ex_funct3;
                            hold_ebreak_p1     <= ex_ebreak;
                            hold_inst_valid_p1 <= ex_inst_valid;
                            state              <= LS_REQ;
                        end
                    end
                end
                LS_REQ: begin
                    if (dm_gnt) begin
                        if (hold_we_p1) begin
                            ls_wb_p2 <= {hold_waddr_p1, 32'h0, 32'h0, hold_pc_p1, hold_inst_p1,
                                         hold_ebreak_p1, hold_inst_valid_p1, hold_rf_we_p1, 8'h00};
                            state    <= LS_IDLE;
                        end else begin
                            state <= LS_WAIT;
                        end
                    end
                end
                LS_WAIT: begin
                    if (dm_rvalid) begin
                        ls_wb_p2 <= {hold_waddr_p1, ext_data, dm_rdata, hold_pc_p1, hold_inst_p1,
                                     hold_ebreak_p1, hold_inst_valid_p1, hold_rf_we_p1,
                                     load_rmask(hold_funct3_p1)};
                        state    <= LS_IDLE;
                    end
                end
                default: state <= LS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// Self-checking bench for ysyx22041405_lsu: directed scenarios plus randomized
// operations compared against a behavioural model of the load/store rules.
module tb_ysyx22041405_lsu;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ex_valid = 1'b0;
    logic         ex_ready;
    logic [31:0]  ex_pc = '0, ex_inst = '0, ex_alu_result = '0, ex_store_data = '0;
    logic [4:0]   ex_rf_waddr = '0;
    logic         ex_rf_we = 1'b0, ex_mem_re = 1'b0, ex_mem_we = 1'b0;
    logic [2:0]   ex_funct3 = '0;
    logic         ex_ebreak = 1'b0, ex_inst_valid = 1'b0;
    logic         dm_req, dm_we;
    logic [31:0]  dm_addr, dm_wdata;
    logic [3:0]   dm_wstrb;
    logic         dm_gnt = 1'b0, dm_rvalid = 1'b0;
    logic [31:0]  dm_rdata = '0;
    logic [143:0] msg;
    logic         ls_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ysyx22041405_lsu #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_inst(ex_inst), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_rf_waddr(ex_rf_waddr), .ex_rf_we(ex_rf_we),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_funct3(ex_funct3),
        .ex_ebreak(ex_ebreak), .ex_inst_valid(ex_inst_valid),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_wstrb(dm_wstrb), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .LS_WB_message(msg), .ls_busy(ls_busy)
    );

    // Reference: expected bundle (and which fields are defined), whether memory is touched,
    // and the store lanes, all derived from access size / offset arithmetic.
    function automatic void model(
        input logic [31:0] pc, inst, alu, sdata, input logic [4:0] waddr,
        input logic rf_we, re, we, input logic [2:0] f3, input logic ebreak, ivalid,
        input logic [31:0] rdata, output logic [143:0] exp, output logic [143:0] care,
        output bit access, output logic [3:0] strb, output logic [31:0] wdata);
        int off, nbytes;
        bit legal;
        logic [31:0] sh, val;
        logic [7:0] mask;
        off = int'(alu[1:0]);
        case (f3[1:0])
            2'd0: nbytes = 1;
            2'd1: nbytes = 2;
            2'd2: nbytes = 4;
            default: nbytes = 0;
        endcase
        legal  = (nbytes != 0) && (re ? !(f3[2] && nbytes == 4) : !f3[2]);
        access = (re || we) && legal && ((off % (nbytes == 0 ? 1 : nbytes)) == 0);
        strb   = (nbytes == 1) ? 4'(1 << off) : (nbytes == 2) ? 4'(3 << off) : 4'hF;
        wdata  = (nbytes == 1) ? (sdata & 32'hFF) * 32'h0101_0101 :
                 (nbytes == 2) ? (sdata & 32'hFFFF) * 32'h0001_0001 : sdata;
        sh = rdata >> (8 * off);
        if (nbytes == 1) begin
            val = sh & 32'hFF;
            if (!f3[2] && val >= 32'h80) val = val - 32'h100;
            mask = 8'h01;
        end else if (nbytes == 2) begin
            val = sh & 32'hFFFF;
            if (!f3[2] && val >= 32'h8000) val = val - 32'h1_0000;
            mask = 8'h03;
        end else begin
            val  = sh;
            mask = 8'h0F;
        end
        if (!(re || we)) begin
            exp  = {waddr, alu, 32'h0, pc, inst, ebreak, ivalid, rf_we, 8'h00};
            care = '1;
        end else if (!access) begin
            exp  = {5'h0, 32'h0, 32'h0, pc, inst, 1'b0, 1'b0, 1'b0, 8'h00};
            care = {69'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 2'b11, 8'hFF};
        end else if (we) begin
            exp  = {5'h0, 32'h0, 32'h0, pc, inst, ebreak, ivalid, 1'b0, 8'h00};
            care = {37'h0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 8'hFF};
        end else begin
            exp  = {waddr, val, rdata, pc, inst, ebreak, ivalid, rf_we, mask};
            care = '1;
        end
    endfunction

    task automatic run_op(input logic [31:0] pc, inst, alu, sdata, input logic [4:0] waddr,
                          input logic rf_we, re, we, input logic [2:0] f3,
                          input logic ebreak, ivalid, input int gnt_dly, rv_dly,
                          input logic [31:0] rdata, input bit idle_after);
        logic [143:0] exp, care;
        bit access;
        logic [3:0] strb;
        logic [31:0] wd;
        model(pc, inst, alu, sdata, waddr, rf_we, re, we, f3, ebreak, ivalid, rdata,
              exp, care, access, strb, wd);
        ex_pc = pc; ex_inst = inst; ex_alu_result = alu; ex_store_data = sdata;
        ex_rf_waddr = waddr; ex_rf_we = rf_we; ex_mem_re = re; ex_mem_we = we;
        ex_funct3 = f3; ex_ebreak = ebreak; ex_inst_valid = ivalid; ex_valid = 1'b1;
        #1;
        checks++;
        if (ex_ready !== 1'b1) begin
            failures++; $display("FAIL op_ready: ex_ready=%b expected 1", ex_ready);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        if (access) begin
            for (int d = 0; d <= gnt_dly; d++) begin
                dm_gnt    = (d == gnt_dly);
                dm_rvalid = (d != gnt_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
                dm_rdata  = $urandom;
                @(negedge clk);
                checks++;
                if (dm_req !== 1'b1 || dm_addr !== alu || dm_we !== we || ex_ready !== 1'b0 || msg !== '0) begin
                    failures++;
                    $display("FAIL req_phase: req=%b addr=%h we=%b ready=%b msg=%h expected req=1 addr=%h we=%b ready=0 msg=0",
                             dm_req, dm_addr, dm_we, ex_ready, msg, alu, we);
                end
                if (we) begin
                    checks++;
                    if (dm_wstrb !== strb || dm_wdata !== wd) begin
                        failures++;
                        $display("FAIL store_lanes: wstrb=%b wdata=%h expected wstrb=%b wdata=%h",
                                 dm_wstrb, dm_wdata, strb, wd);
                    end
                end
                @(posedge clk); #1;
            end
            dm_gnt = 1'b0;
            dm_rvalid = 1'b0;
            if (re) begin
                for (int d = 0; d <= rv_dly; d++) begin
                    dm_rvalid = (d == rv_dly);
                    dm_rdata  = (d == rv_dly) ? rdata : $urandom;
                    @(negedge clk);
                    checks++;
                    if (dm_req !== 1'b0 || ex_ready !== 1'b0 || msg !== '0) begin
                        failures++;
                        $display("FAIL wait_phase: req=%b ready=%b msg=%h expected req=0 ready=0 msg=0",
                                 dm_req, ex_ready, msg);
                    end
                    @(posedge clk); #1;
                end
                dm_rvalid = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if ((msg & care) !== (exp & care)) begin
            failures++;
            $display("FAIL bundle: got %h expected %h (care %h)", msg, exp, care);
        end
        checks++;
        if (dm_req !== 1'b0 || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_retire: req=%b ready=%b expected req=0 ready=1", dm_req, ex_ready);
        end
        if (idle_after) begin
            @(posedge clk); #1;
            @(negedge clk);
            checks++;
            if (msg !== '0) begin
                failures++; $display("FAIL bubble: msg=%h expected 0", msg);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (msg !== '0 || dm_req !== 1'b0 || ls_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: msg=%h req=%b busy=%b expected all 0", msg, dm_req, ls_busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (ex_ready !== 1'b1 || ls_busy !== 1'b0 || msg !== '0 || dm_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: ready=%b busy=%b msg=%h req=%b expected 1 0 0 0",
                     ex_ready, ls_busy, msg, dm_req);
        end
    endtask

    task automatic test_addi;
        run_op(32'h8000_0000, 32'h0050_0193, 32'h0000_0005, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0,
               3'b000, 1'b0, 1'b1, 0, 0, 32'h0, 1'b0);
        checks++;
        if (msg[143:139] !== 5'd3 || msg[138:107] !== 32'h5 || msg[7:0] !== 8'h00 || msg[9] !== 1'b1) begin
            failures++;
            $display("FAIL addi_fields: waddr=%0d wdata=%h rmask=%h valid=%b expected 3 5 00 1",
                     msg[143:139], msg[138:107], msg[7:0], msg[9]);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (msg !== '0) begin
            failures++; $display("FAIL addi_bubble: msg=%h expected 0", msg);
        end
    endtask

    task automatic test_lb;
        run_op(32'h8000_0010, 32'h0030_0083, 32'h8000_0003, 32'h0, 5'd1, 1'b1, 1'b1, 1'b0,
               3'b000, 1'b0, 1'b1, 0, 0, 32'h80AA_BBCC, 1'b0);
        checks++;
        if (msg[138:107] !== 32'hFFFF_FF80 || msg[106:75] !== 32'h80AA_BBCC || msg[7:0] !== 8'h01) begin
            failures++;
            $display("FAIL lb_fields: wdata=%h rdata=%h rmask=%h expected ffffff80 80aabbcc 01",
                     msg[138:107], msg[106:75], msg[7:0]);
        end
    endtask

    task automatic test_sh_delay;
        run_op(32'h8000_0014, 32'h0011_1123, 32'h8000_0002, 32'h1234_ABCD, 5'd0, 1'b0, 1'b0, 1'b1,
               3'b001, 1'b0, 1'b1, 3, 0, 32'h0, 1'b1);
    endtask

    task automatic test_misaligned;
        run_op(32'h8000_0018, 32'h0010_2283, 32'h8000_0001, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0,
               3'b010, 1'b0, 1'b1, 0, 0, 32'h0, 1'b0);
        checks++;
        if (msg[9] !== 1'b0 || msg[8] !== 1'b0 || msg[42:11] === 32'h0) begin
            failures++;
            $display("FAIL misaligned_fields: valid=%b rf_we=%b inst=%h expected 0 0 nonzero",
                     msg[9], msg[8], msg[42:11]);
        end
    endtask

    task automatic test_reset_wait;
        ex_pc = 32'h8000_0020; ex_inst = 32'h0000_2303; ex_alu_result = 32'h8000_0008;
        ex_rf_waddr = 5'd6; ex_rf_we = 1'b1; ex_mem_re = 1'b1; ex_mem_we = 1'b0;
        ex_funct3 = 3'b010; ex_ebreak = 1'b0; ex_inst_valid = 1'b1; ex_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        ex_valid = 1'b0; dm_gnt = 1'b1;
        @(posedge clk); #1;
        dm_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (ls_busy !== 1'b1 || dm_req !== 1'b0 || ex_ready !== 1'b0) begin
            failures++;
            $display("FAIL wait_entry: busy=%b req=%b ready=%b expected 1 0 0", ls_busy, dm_req, ex_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        checks++;
        if (dm_req !== 1'b0 || msg !== '0 || ex_ready !== 1'b1 || ls_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_wait: req=%b msg=%h ready=%b busy=%b expected 0 0 1 0",
                     dm_req, msg, ex_ready, ls_busy);
        end
        @(posedge clk); #1;
        dm_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (msg !== '0 || dm_req !== 1'b0) begin
            failures++; $display("FAIL late_rvalid: msg=%h req=%b expected 0 0", msg, dm_req);
        end
    endtask

    task automatic test_reset_req;
        ex_pc = 32'h8000_0024; ex_inst = 32'h0062_2023; ex_alu_result = 32'h8000_000C;
        ex_store_data = 32'h5555_AAAA; ex_rf_we = 1'b0; ex_mem_re = 1'b0; ex_mem_we = 1'b1;
        ex_funct3 = 3'b010; ex_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_req !== 1'b1) begin
            failures++; $display("FAIL req_before_reset: req=%b expected 1", dm_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dm_req !== 1'b0 || ls_busy !== 1'b0 || ex_ready !== 1'b1 || msg !== '0) begin
            failures++;
            $display("FAIL reset_req: req=%b busy=%b ready=%b msg=%h expected 0 0 1 0",
                     dm_req, ls_busy, ex_ready, msg);
        end
    endtask

    task automatic test_load_then_addi;
        logic [143:0] exp_ld, care_ld, exp_ad, care_ad;
        bit acc;
        logic [3:0] s;
        logic [31:0] w;
        model(32'h8000_0030, 32'h0042_2383, 32'h8000_0004, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0,
              3'b010, 1'b0, 1'b1, 32'hDEAD_BEEF, exp_ld, care_ld, acc, s, w);
        model(32'h8000_0034, 32'h0050_0193, 32'h0000_0005, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0,
              3'b000, 1'b0, 1'b1, 32'h0, exp_ad, care_ad, acc, s, w);
        ex_pc = 32'h8000_0030; ex_inst = 32'h0042_2383; ex_alu_result = 32'h8000_0004;
        ex_rf_waddr = 5'd7; ex_rf_we = 1'b1; ex_mem_re = 1'b1; ex_mem_we = 1'b0;
        ex_funct3 = 3'b010; ex_ebreak = 1'b0; ex_inst_valid = 1'b1; ex_valid = 1'b1;
        #1;
        @(posedge clk); #1;
        ex_pc = 32'h8000_0034; ex_inst = 32'h0050_0193; ex_alu_result = 32'h0000_0005;
        ex_rf_waddr = 5'd3; ex_mem_re = 1'b0; ex_funct3 = 3'b000;
        for (int c = 0; c < 3; c++) begin
            dm_gnt    = (c == 1);
            dm_rvalid = (c == 2);
            dm_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            checks++;
            if (ex_ready !== 1'b0 || msg !== '0) begin
                failures++;
                $display("FAIL hold_off_%0d: ready=%b msg=%h expected ready=0 msg=0", c, ex_ready, msg);
            end
            @(posedge clk); #1;
        end
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if ((msg & care_ld) !== exp_ld || ex_ready !== 1'b1) begin
            failures++;
            $display("FAIL load_retire: msg=%h ready=%b expected %h ready=1", msg, ex_ready, exp_ld);
        end
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (msg !== exp_ad) begin
            failures++; $display("FAIL addi_after_load: msg=%h expected %h", msg, exp_ad);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (msg !== '0) begin
            failures++; $display("FAIL after_pair_bubble: msg=%h expected 0", msg);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++)
            run_op(32'h8000_0100 + 32'(4 * i), 32'h0000_0013 | 32'(i << 7), $urandom, 32'h0,
                   5'(i + 8), 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 0, 0, 32'h0, i == 3);
    endtask

    task automatic test_random;
        logic [2:0] ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        int kind;
        logic [31:0] alu;
        logic [2:0] f3;
        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            else if (kind == 2) f3 = 3'($urandom_range(0, 2));
            else f3 = ld_f3[$urandom_range(0, 4)];
            alu = (kind == 0) ? $urandom : (32'h8000_0000 | 32'($urandom_range(0, 255)));
            if (kind != 0 && $urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) alu[0] = 1'b0;
                if (f3[1:0] == 2'b10) alu[1:0] = 2'b00;
            end
            run_op($urandom, $urandom | 32'h1, alu, $urandom, 5'($urandom_range(0, 31)),
                   1'($urandom_range(0, 1)), kind == 1, kind == 2, f3,
                   ($urandom_range(0, 15) == 0), 1'b1, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_lb;
        test_sh_delay;
        test_misaligned;
        test_reset_wait;
        test_reset_req;
        test_load_then_addi;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
